// File: rtl/gated_count_pkg.sv
// Shared definitions for the gated counter burst sequencer.
//   state_t      : sequencer FSM state encoding (ST_IDLE, ST_RUN, ST_GAP, ST_DONE)
//   DEF_*_W      : default widths for the timers, burst index and counter
package gated_count_pkg;

    localparam int DEF_LEN_W   = 8;
    localparam int DEF_BURST_W = 4;
    localparam int DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/gated_counter.sv
// Free-running counter that advances only while enable is high.
// It wraps naturally modulo 2^CNT_W.
//   clk    : system clock, rising edge
//   rst    : synchronous, active-high reset (clears count)
//   enable : count-enable; count advances on each rising edge where it is high
//   count  : current counter value
module gated_counter
    import gated_count_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gated_count_sequencer.sv
// Burst scheduler for the gated counter. An accepted start latches the
// configuration, then drives enable high for run_len cycles, low for gap_len
// cycles, repeated num_bursts times, and ends with a one-cycle done pulse.
//   clk        : system clock, rising edge
//   rst        : synchronous, active-high reset (also resets the counter)
//   start      : request to begin a sequence, honoured only in IDLE
//   abort      : return to IDLE next cycle without a done pulse
//   run_len    : enable-high cycles per burst (latched on accepted start)
//   gap_len    : enable-low cycles between bursts (latched on accepted start)
//   num_bursts : bursts per sequence (latched on accepted start)
//   enable     : registered enable into the gated counter
//   count      : gated counter value
//   busy       : high while in RUN or GAP
//   done       : one-cycle pulse when the last burst completes
//   burst_idx  : 0-based index of the current burst
//   dbg_state  : current FSM state, for observation only
//
// Handshake: start is a level sampled on each rising edge while in IDLE; there
// is no ready. A start seen outside IDLE, or together with abort, is dropped.
module gated_count_sequencer
    import gated_count_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [LEN_W-1:0]   run_len,
    input  logic [LEN_W-1:0]   gap_len,
    input  logic [BURST_W-1:0] num_bursts,
    output logic               enable,
    output logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] burst_idx,
    output logic [1:0]         dbg_state
);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     timer_q, timer_d;
    logic [BURST_W-1:0]   burst_d;
    logic [LEN_W-1:0]     run_len_q, run_len_d;
    logic [LEN_W-1:0]     gap_len_q, gap_len_d;
    logic [BURST_W-1:0]   num_bursts_q, num_bursts_d;

    // Next-state, phase timer, burst index and config latch.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        burst_d      = burst_idx;
        run_len_d    = run_len_q;
        gap_len_d    = gap_len_q;
        num_bursts_d = num_bursts_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    run_len_d    = run_len;
                    gap_len_d    = gap_len;
                    num_bursts_d = num_bursts;
                    burst_d      = '0;
                    // Empty sequences skip straight to the done pulse.
                    if (run_len == '0 || num_bursts == '0) begin
                        state_d = ST_DONE;
                        timer_d = '0;
                    end else begin
                        state_d = ST_RUN;
                        timer_d = run_len - LEN_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    burst_d = '0;
                end else if (timer_q == '0) begin
                    if (burst_idx == num_bursts_q - BURST_W'(1)) begin
                        state_d = ST_DONE;
                        timer_d = '0;
                    end else if (gap_len_q == '0) begin
                        // Back-to-back bursts: stay in RUN, enable never drops.
                        burst_d = burst_idx + BURST_W'(1);
                        timer_d = run_len_q - LEN_W'(1);
                    end else begin
                        state_d = ST_GAP;
                        timer_d = gap_len_q - LEN_W'(1);
                    end
                end else begin
                    timer_d = timer_q - LEN_W'(1);
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    burst_d = '0;
                end else if (timer_q == '0) begin
                    state_d = ST_RUN;
                    burst_d = burst_idx + BURST_W'(1);
                    timer_d = run_len_q - LEN_W'(1);
                end else begin
                    timer_d = timer_q - LEN_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                timer_d = '0;
                // burst_idx keeps its final value unless the sequence is aborted.
                if (abort) begin
                    burst_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                burst_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            burst_idx    <= '0;
            run_len_q    <= '0;
            gap_len_q    <= '0;
            num_bursts_q <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            burst_idx    <= burst_d;
            run_len_q    <= run_len_d;
            gap_len_q    <= gap_len_d;
            num_bursts_q <= num_bursts_d;
            enable       <= (state_d == ST_RUN);
            busy         <= (state_d == ST_RUN) || (state_d == ST_GAP);
            done         <= (state_d == ST_DONE);
        end
    end

    assign dbg_state = state_q;

    gated_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .count  (count)
    );

endmodule
